// File: rtl/key_entry_pkg.sv
// Shared constants, state type and press-encoding helpers for the keypad digit-entry block.
package key_entry_pkg;

    localparam logic [3:0] KEY_BKSP = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;
    localparam logic [3:0] KEY_ENT  = 4'd12;
    localparam int         NUM_W    = 32;

    typedef enum logic {EDIT, OFFER} entry_state_t;

    function automatic logic isOneHot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    function automatic logic [3:0] oneHotIndex(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer: the stable vector only follows the
// synchronised keys once they have stayed unchanged for DEBOUNCE_CYCLES cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_in,
    output logic [15:0] key_stable
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      syncA;
    logic [15:0]      syncB;
    logic [15:0]      candidate;
    logic [CNT_W-1:0] count;

    // Any change restarts the window; the counter saturates at CNT_MAX while the keys hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA      <= '0;
            syncB      <= '0;
            candidate  <= '0;
            count      <= '0;
            key_stable <= '0;
        end else begin
            syncA <= key_in;
            syncB <= syncA;
            if (syncB != candidate) begin
                candidate <= syncB;
                count     <= '0;
            end else if (count == CNT_MAX) begin
                key_stable <= candidate;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_digit_entry.sv
// Keypad front end: debounced single-key presses edit an 8-nibble digit buffer, and Enter
// offers the buffer to a consumer over valid/ready.
module key_digit_entry
    import key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int MAX_DIGITS      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] key,
    output logic [31:0] num_data,
    output logic [3:0]  digit_cnt,
    output logic        key_pulse,
    output logic [3:0]  key_code,
    output logic        entry_valid,
    output logic [31:0] entry_value,
    input  logic        entry_ready
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    // Handshake: an entry transfers on any edge where entry_valid and entry_ready are both
    // high; once raised, entry_valid and entry_value hold until that transfer.

    logic [15:0]      keyStable;
    logic [15:0]      keyStablePrev;
    logic [15:0]      press;
    logic             accept;
    logic [3:0]       pressCode;
    logic             handshake;
    entry_state_t     state;
    entry_state_t     stateNext;
    logic [NUM_W-1:0] numNext;
    logic [NUM_W-1:0] entryValueNext;
    logic [3:0]       cntNext;
    logic             entryValidNext;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key),
        .key_stable(keyStable)
    );

    // Chords and ghosted multi-key vectors produce no press at all.
    assign press     = keyStable & ~keyStablePrev;
    assign pressCode = oneHotIndex(press);
    assign accept    = en & isOneHot(press);
    assign handshake = entry_valid & entry_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EDIT;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            EDIT:  if (accept && pressCode == KEY_ENT && digit_cnt != 4'd0) stateNext = OFFER;
            OFFER: if (handshake) stateNext = EDIT;
            default: stateNext = EDIT;
        endcase
    end

    // The handshake is honoured even with en low so a transfer the consumer saw always lands.
    always_comb begin
        numNext        = num_data;
        cntNext        = digit_cnt;
        entryValidNext = entry_valid;
        entryValueNext = entry_value;
        if (state == OFFER) begin
            if (handshake) begin
                entryValidNext = 1'b0;
                numNext        = '0;
                cntNext        = 4'd0;
            end
        end else if (accept) begin
            case (pressCode)
                KEY_BKSP: begin
                    if (digit_cnt != 4'd0) begin
                        numNext = {4'h0, num_data[31:4]};
                        cntNext = digit_cnt - 4'd1;
                    end
                end
                KEY_CLR: begin
                    numNext = '0;
                    cntNext = 4'd0;
                end
                KEY_ENT: begin
                    if (digit_cnt != 4'd0) begin
                        entryValueNext = num_data;
                        entryValidNext = 1'b1;
                    end
                end
                default: begin
                    if (pressCode <= 4'd9 && digit_cnt < MAX_CNT) begin
                        numNext = {num_data[27:0], pressCode};
                        cntNext = digit_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyStablePrev <= '0;
            num_data      <= '0;
            digit_cnt     <= 4'd0;
            key_pulse     <= 1'b0;
            key_code      <= 4'd0;
            entry_valid   <= 1'b0;
            entry_value   <= '0;
        end else begin
            keyStablePrev <= keyStable;
            num_data      <= numNext;
            digit_cnt     <= cntNext;
            key_pulse     <= accept;
            if (accept) key_code <= pressCode;
            entry_valid   <= entryValidNext;
            entry_value   <= entryValueNext;
        end
    end

endmodule

// File: tb/tb_key_digit_entry.sv
// Directed bench for key_digit_entry with a 4-cycle debounce window; each press pushes
// its expected code/buffer/count, and a monitor checks them whenever key_pulse fires.
module tb_key_digit_entry;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] key;
    logic [31:0] num_data;
    logic [3:0]  digit_cnt;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic        entry_valid;
    logic [31:0] entry_value;
    logic        entry_ready;

    logic [39:0] exp_q[$];
    logic [31:0] ent_q[$];
    int          n_checks;
    int          n_fail;
    int          pulse_count;

    key_digit_entry #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .key        (key),
        .num_data   (num_data),
        .digit_cnt  (digit_cnt),
        .key_pulse  (key_pulse),
        .key_code   (key_code),
        .entry_valid(entry_valid),
        .entry_value(entry_value),
        .entry_ready(entry_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int k, input logic [31:0] exp_num, input logic [3:0] exp_cnt);
        exp_q.push_back({4'(k), exp_num, exp_cnt});
        key = 16'd1 << k;
        tick(10);
        key = 16'd0;
        tick(8);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_pulse) begin
                pulse_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got code %0d expected no pulse", key_code);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    check("pulse_code", 32'(key_code), 32'(e[39:36]));
                    check("pulse_num", num_data, e[35:4]);
                    check("pulse_cnt", 32'(digit_cnt), 32'(e[3:0]));
                end
            end
            if (entry_valid && entry_ready) begin
                if (ent_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got %h expected no transfer", entry_value);
                end else begin
                    check("entry_value", entry_value, ent_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start_pulses;
        int pulses_seen;
        int pulse_edge;
        n_checks    = 0;
        n_fail      = 0;
        pulse_count = 0;
        rst_n       = 1'b0;
        en          = 1'b1;
        key         = 16'd0;
        entry_ready = 1'b0;
        tick(2);
        check("rst_num", num_data, 32'd0);
        check("rst_cnt", 32'(digit_cnt), 32'd0);
        check("rst_pulse", 32'(key_pulse), 32'd0);
        check("rst_valid", 32'(entry_valid), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Latency: key sampled first on edge 0, pulse expected on edge 7 only.
        exp_q.push_back({4'd7, 32'h7, 4'd1});
        key = 16'd1 << 7;
        pulses_seen = 0;
        pulse_edge  = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (key_pulse) begin
                pulses_seen++;
                pulse_edge = i;
            end
        end
        check("latency_edge", 32'(pulse_edge), 32'd7);
        check("latency_count", 32'(pulses_seen), 32'd1);
        key = 16'd0;
        tick(8);

        start_pulses = pulse_count;
        key = 16'd1 << 3;
        tick(3);
        key = 16'd0;
        tick(10);
        check("glitch_pulses", 32'(pulse_count), 32'(start_pulses));
        check("glitch_num", num_data, 32'h7);

        press_key(11, 32'h0, 4'd0);
        press_key(1, 32'h1, 4'd1);
        press_key(2, 32'h12, 4'd2);
        press_key(3, 32'h123, 4'd3);
        press_key(10, 32'h12, 4'd2);
        press_key(9, 32'h129, 4'd3);
        press_key(11, 32'h0, 4'd0);

        press_key(1, 32'h1, 4'd1);
        press_key(2, 32'h12, 4'd2);
        press_key(3, 32'h123, 4'd3);
        press_key(4, 32'h1234, 4'd4);
        press_key(5, 32'h12345, 4'd5);
        press_key(6, 32'h123456, 4'd6);
        press_key(7, 32'h1234567, 4'd7);
        press_key(8, 32'h12345678, 4'd8);
        press_key(9, 32'h12345678, 4'd8);
        press_key(11, 32'h0, 4'd0);

        press_key(4, 32'h4, 4'd1);
        press_key(2, 32'h42, 4'd2);
        press_key(12, 32'h42, 4'd2);
        check("offer_valid", 32'(entry_valid), 32'd1);
        check("offer_value", entry_value, 32'h42);
        press_key(5, 32'h42, 4'd2);
        check("offer_hold_valid", 32'(entry_valid), 32'd1);
        check("offer_hold_value", entry_value, 32'h42);
        ent_q.push_back(32'h42);
        entry_ready = 1'b1;
        tick(1);
        entry_ready = 1'b0;
        check("post_hs_valid", 32'(entry_valid), 32'd0);
        check("post_hs_num", num_data, 32'h0);
        check("post_hs_cnt", 32'(digit_cnt), 32'd0);
        tick(2);

        start_pulses = pulse_count;
        key = (16'd1 << 1) | (16'd1 << 2);
        tick(10);
        key = 16'd0;
        tick(8);
        check("chord_pulses", 32'(pulse_count), 32'(start_pulses));

        press_key(12, 32'h0, 4'd0);
        check("enter_empty_valid", 32'(entry_valid), 32'd0);
        press_key(13, 32'h0, 4'd0);

        start_pulses = pulse_count;
        en  = 1'b0;
        key = 16'd1 << 5;
        tick(10);
        key = 16'd0;
        tick(8);
        key = 16'd1 << 5;
        tick(10);
        en = 1'b1;
        tick(5);
        key = 16'd0;
        tick(8);
        check("en_low_pulses", 32'(pulse_count), 32'(start_pulses));
        check("en_low_num", num_data, 32'h0);

        press_key(6, 32'h6, 4'd1);
        key = 16'd1 << 3;
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_num", num_data, 32'd0);
        check("async_rst_cnt", 32'(digit_cnt), 32'd0);
        check("async_rst_code", 32'(key_code), 32'd0);
        check("async_rst_value", entry_value, 32'd0);
        exp_q.push_back({4'd3, 32'h3, 4'd1});
        tick(2);
        rst_n = 1'b1;
        tick(10);
        key = 16'd0;
        tick(8);

        check("leftover_pulses", 32'(exp_q.size()), 32'd0);
        check("leftover_entries", 32'(ent_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
